// File: rtl/main_memory_responder.sv
// main_memory_responder: on-chip word array that answers R_REQ/WB_REQ/FLUSH with a one-cycle MEM_RESP
// after LATENCY wait cycles; a dead IDLE cycle follows every response so a held request is not serviced twice.
module main_memory_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MSG_BITS = 4,
  parameter int INDEX_BITS = 10,
  parameter int LATENCY = 2,
  parameter logic [MSG_BITS-1:0] NO_REQ = MSG_BITS'(0),
  parameter logic [MSG_BITS-1:0] R_REQ = MSG_BITS'(1),
  parameter logic [MSG_BITS-1:0] WB_REQ = MSG_BITS'(2),
  parameter logic [MSG_BITS-1:0] FLUSH = MSG_BITS'(3),
  parameter logic [MSG_BITS-1:0] MEM_RESP = MSG_BITS'(4)
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic [MSG_BITS-1:0] interface2mem_msg_i,
  input  logic [ADDRESS_WIDTH-1:0] interface2mem_address_i,
  input  logic [DATA_WIDTH-1:0] interface2mem_data_i,
  output logic [MSG_BITS-1:0] mem2interface_msg_o,
  output logic [ADDRESS_WIDTH-1:0] mem2interface_address_o,
  output logic [DATA_WIDTH-1:0] mem2interface_data_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;
  localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d, raddr_q, raddr_d, sel_addr;
  logic rd_q, rd_d;
  logic [MSG_BITS-1:0] rmsg_q, rmsg_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [2**INDEX_BITS];
  logic is_rd, is_wr, accept, resp, wr_en;
  // With LATENCY==0 the response is built at the accept edge, so address and read data come straight from the inputs.
  always_comb begin
    is_rd = interface2mem_msg_i == R_REQ;
    is_wr = interface2mem_msg_i == WB_REQ || interface2mem_msg_i == FLUSH;
    accept = state_q == IDLE && (is_rd || is_wr);
    wr_en = reset_n_i && state_q == IDLE && is_wr;
    resp = (accept && LATENCY == 0) || (state_q == WAIT && cnt_q == '0);
    sel_addr = state_q == IDLE ? interface2mem_address_i : addr_q;
    state_d = accept ? (LATENCY == 0 ? RESPOND : WAIT)
            : state_q == WAIT ? (cnt_q == '0 ? RESPOND : WAIT) : IDLE;
    cnt_d = accept ? CW'(LATENCY > 0 ? LATENCY - 1 : 0)
          : (state_q == WAIT && cnt_q != '0) ? cnt_q - 1'b1 : '0;
    addr_d = accept ? interface2mem_address_i : addr_q;
    rd_d = accept ? is_rd : rd_q;
    rmsg_d = resp ? MEM_RESP : NO_REQ;
    raddr_d = resp ? sel_addr : '0;
    rdata_d = (resp && (state_q == IDLE ? is_rd : rd_q)) ? mem_q[sel_addr[INDEX_BITS-1:0]] : '0;
  end
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      rd_q <= 1'b0;
      rmsg_q <= NO_REQ;
      raddr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      rd_q <= rd_d;
      rmsg_q <= rmsg_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
    end
  end
  // Array contents survive reset, so it gets no reset branch.
  always_ff @(posedge clock_i) begin
    if (wr_en) mem_q[interface2mem_address_i[INDEX_BITS-1:0]] <= interface2mem_data_i;
  end
  assign mem2interface_msg_o = rmsg_q;
  assign mem2interface_address_o = raddr_q;
  assign mem2interface_data_o = rdata_q;
endmodule
